// File: rtl/video_op_engine.sv
// Page-level video operation engine: fill, copy and blit of whole pages,
// driven by a one-shot CPU request and reporting completion with a done pulse.
module video_op_engine #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 200,
    parameter int PIX_W  = 4,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [1:0]        cmd_dst,
    input  logic [1:0]        cmd_src,
    input  logic [PIX_W-1:0]  cmd_color,
    output logic              busy,
    output logic              done,
    output logic              pg_rd_en,
    output logic [1:0]        pg_rd_page,
    output logic [ADDR_W-1:0] pg_rd_addr,
    input  logic [PIX_W-1:0]  pg_rd_data,
    output logic              pg_wr_en,
    output logic [1:0]        pg_wr_page,
    output logic [ADDR_W-1:0] pg_wr_addr,
    output logic [PIX_W-1:0]  pg_wr_data,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [PIX_W-1:0]  fb_wr_data
);

    localparam int unsigned        N    = WIDTH * HEIGHT;
    localparam logic [ADDR_W-1:0]  LAST = ADDR_W'(N - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [1:0] OP_FILL = 2'd0;
    localparam logic [1:0] OP_COPY = 2'd1;
    localparam logic [1:0] OP_BLIT = 2'd2;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [1:0]        op_q, op_d;
    logic [1:0]        dst_q, dst_d;
    logic [1:0]        src_q, src_d;
    logic [PIX_W-1:0]  color_q, color_d;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        op_d    = op_q;
        dst_d   = dst_q;
        src_d   = src_q;
        color_d = color_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    dst_d   = cmd_dst;
                    src_d   = cmd_src;
                    color_d = cmd_color;
                    a_d     = '0;
                    case (cmd_op)
                        OP_FILL:          state_d = S_FILL;
                        OP_COPY, OP_BLIT: state_d = S_STREAM;
                        default:          state_d = S_DONE;
                    endcase
                end
            end
            S_FILL: begin
                if (a_q == LAST) state_d = S_DONE;
                else             a_d     = a_q + 1'b1;
            end
            S_STREAM: begin
                if (a_q == LAST) state_d = S_DRAIN;
                else             a_d     = a_q + 1'b1;
            end
            S_DRAIN: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Reads lead writes by one cycle: STREAM writes the word read at a-1,
    // DRAIN writes the last word at a (the counter has stopped at N-1).
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = '0;
        if (state_q == S_STREAM && a_q != '0) begin
            wr_en   = 1'b1;
            wr_addr = a_q - 1'b1;
        end else if (state_q == S_DRAIN) begin
            wr_en   = 1'b1;
            wr_addr = a_q;
        end
    end

    // Outputs are forced idle while reset is held so nothing strobes during reset.
    always_comb begin
        cmd_ready  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        pg_rd_en   = 1'b0;
        pg_rd_page = '0;
        pg_rd_addr = '0;
        pg_wr_en   = 1'b0;
        pg_wr_page = '0;
        pg_wr_addr = '0;
        pg_wr_data = '0;
        fb_wr_en   = 1'b0;
        fb_wr_addr = '0;
        fb_wr_data = '0;
        if (!reset) begin
            cmd_ready = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: cmd_ready = 1'b1;
                S_FILL: begin
                    busy       = 1'b1;
                    pg_wr_en   = 1'b1;
                    pg_wr_page = dst_q;
                    pg_wr_addr = a_q;
                    pg_wr_data = color_q;
                end
                S_STREAM, S_DRAIN: begin
                    busy = 1'b1;
                    if (state_q == S_STREAM) begin
                        pg_rd_en   = 1'b1;
                        pg_rd_page = src_q;
                        pg_rd_addr = a_q;
                    end
                    if (wr_en && op_q == OP_COPY) begin
                        pg_wr_en   = 1'b1;
                        pg_wr_page = dst_q;
                        pg_wr_addr = wr_addr;
                        pg_wr_data = pg_rd_data;
                    end else if (wr_en) begin
                        fb_wr_en   = 1'b1;
                        fb_wr_addr = wr_addr;
                        fb_wr_data = pg_rd_data;
                    end
                end
                S_DONE: begin
                    busy = 1'b1;
                    done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            op_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            op_q    <= op_d;
            dst_q   <= dst_d;
            src_q   <= src_d;
            color_q <= color_d;
        end
    end

endmodule

// File: doc/video_op_engine.md
Name: video_op_engine

Overview:
- Executes page-level video operations (fill page, copy page, blit page to the displayed frame buffer) requested by the VM CPU core.
- Sits between the CPU's video instructions and the page/front-buffer memories, so the CPU only issues a request and waits for completion.
- Acts as responder to the CPU's request/ready handshake and as initiator on the page RAM and frame-buffer write ports.

Parameters:
WIDTH, 320, pixels per line
HEIGHT, 200, lines per page
PIX_W, 4, bits per pixel (palette index)
ADDR_W, 16, pixel address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
cmd_valid  in  1  CPU request strobe
cmd_ready  out  1  engine idle, can accept a request
cmd_op  in  2  0=fill, 1=copy, 2=blit, 3=reserved
cmd_dst  in  2  destination page (fill, copy)
cmd_src  in  2  source page (copy, blit)
cmd_color  in  PIX_W  fill colour
busy  out  1  operation in progress
done  out  1  one-cycle completion pulse
pg_rd_en  out  1  page RAM read strobe
pg_rd_page  out  2  page RAM read page
pg_rd_addr  out  ADDR_W  page RAM read address
pg_rd_data  in  PIX_W  page RAM read data, valid exactly one cycle after pg_rd_en
pg_wr_en  out  1  page RAM write strobe
pg_wr_page  out  2  page RAM write page
pg_wr_addr  out  ADDR_W  page RAM write address
pg_wr_data  out  PIX_W  page RAM write data
fb_wr_en  out  1  front buffer write strobe
fb_wr_addr  out  ADDR_W  front buffer write address
fb_wr_data  out  PIX_W  front buffer write data

Behaviour:

Reset and idle:
- reset is synchronous, active-low; clock is clk.
- While reset is low: state=IDLE, cmd_ready=1, busy=0, done=0, and all *_en=0. All address/data outputs are 0.
- Reset low mid-operation aborts immediately. No write strobe occurs in the cycle after reset is sampled low. Page contents are left partially written.

Handshake and command capture:
- cmd_ready=1 only in IDLE. A request is accepted on the edge where cmd_valid&&cmd_ready; call this cycle 0.
- cmd_op, cmd_dst, cmd_src and cmd_color are captured at acceptance. Later changes to these inputs are ignored.
- busy=1 from cycle 1 until the done cycle inclusive.
- cmd_valid held high while busy has no effect.

Addressing:
- N = WIDTH*HEIGHT. A single linear counter a runs 0..N-1, address = y*WIDTH+x, with no wrap.
- After the write to N-1 the counter stops; no address >= N is ever emitted.

States: IDLE, FILL, STREAM, DRAIN, DONE.

FILL (op 0):
- In cycles 1..N: pg_wr_en=1, pg_wr_page=dst, pg_wr_addr=cycle-1, pg_wr_data=color.
- done=1 in cycle N+1 (DONE state). Return to IDLE; cmd_ready=1 in cycle N+2.

STREAM/DRAIN (op 1 copy, op 2 blit):
- In cycles 1..N: pg_rd_en=1, pg_rd_page=src, pg_rd_addr=cycle-1.
- In cycles 2..N+1: write the previous cycle's pg_rd_data to address cycle-2.
  - Copy: pg_wr_en, pg_wr_page=dst.
  - Blit: fb_wr_en.
- Cycle N+1 is DRAIN: no read, final write only. done in cycle N+2; cmd_ready in cycle N+3.
- Copy with src==dst runs normally; the data is unchanged.

Reserved op (3):
- Accepted, with no reads and no writes. done in cycle 1; cmd_ready in cycle 2.

Exclusivity:
- pg_wr_en and fb_wr_en are never high in the same cycle.
- pg_rd_en is never high outside STREAM.

Test Plan:
1. WIDTH=4, HEIGHT=2; fill dst=2 color=0xA -> pg_wr_en high for cycles 1..8 with addr 0..7, page 2, data 0xA; done in cycle 9; cmd_ready back in cycle 10.
2. WIDTH=4, HEIGHT=2; page 1 preloaded with addr+3; copy src=1 dst=3 -> writes in cycles 2..9 with page-3 addr k holding k+3; done in cycle 10; no write to page 1.
3. Default 320x200; blit src=0 with page 0 preloaded pattern (x^y)&0xF -> 64000 fb writes, last at fb_wr_addr=63999; done at cycle 64002; pg_wr_en stays 0 throughout.
4. Back-to-back requests: cmd_valid held high across two fills (color 1, then 5) -> second accepted only in the first cycle cmd_ready=1 after done; no command overlap; final page contents all 5.
5. Reset driven low at cycle 3 of a copy -> no write strobes from the next cycle onward; cmd_ready=1, busy=0; a new fill then completes normally.
6. cmd_op=3 -> done at cycle 1; zero read and write strobes; cmd_ready=1 at cycle 2.
